// File: rtl/sr_fifo_arbiter.sv
// Round-robin arbiter sharing one show-ahead FIFO between two push/pop requesters.
// Blocked requests (push on full, pop on empty) complete with an error after TIMEOUT cycles.
module sr_fifo_arbiter #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic              a_op,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ready,
   output logic              a_err,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_valid,
   input  logic              b_op,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ready,
   output logic              b_err,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              fifo_push,
   output logic              fifo_pop,
   output logic [DATA_W-1:0] fifo_wdata,
   input  logic [DATA_W-1:0] fifo_rdata,
   input  logic              fifo_empty,
   input  logic              fifo_full
);

   typedef enum logic {LAST_A, LAST_B} rr_t;

   rr_t               r_rr, w_rr_next;
   logic [CNT_W-1:0]  r_cnt_a, r_cnt_b;
   logic              r_rvalid_a, r_rvalid_b;
   logic [DATA_W-1:0] r_rdata_a, r_rdata_b;

   logic w_elig_a, w_elig_b;
   logic w_to_a, w_to_b;
   logic w_grant_a, w_grant_b;

   // Blocked counters saturate so TIMEOUT = 0 (never time out) cannot wrap.
   function automatic logic [CNT_W-1:0] cnt_next(input logic             valid,
                                                 input logic             elig,
                                                 input logic             to,
                                                 input logic [CNT_W-1:0] cnt);
      if (!valid || elig || to) return '0;
      if (cnt == {CNT_W{1'b1}}) return cnt;
      return cnt + CNT_W'(1);
   endfunction

   assign w_elig_a = a_valid & (a_op ? !fifo_empty : !fifo_full);
   assign w_elig_b = b_valid & (b_op ? !fifo_empty : !fifo_full);

   assign w_to_a = (TIMEOUT != 0) && !rst && a_valid && !w_elig_a && (r_cnt_a == CNT_W'(TIMEOUT));
   assign w_to_b = (TIMEOUT != 0) && !rst && b_valid && !w_elig_b && (r_cnt_b == CNT_W'(TIMEOUT));

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_grant_a  = 1'b0;
      w_grant_b  = 1'b0;
      w_rr_next  = r_rr;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_wdata = '0;
      if (!rst) begin
         if (w_elig_a && (!w_elig_b || r_rr == LAST_B)) w_grant_a = 1'b1;
         else if (w_elig_b)                               w_grant_b = 1'b1;
      end
      if (w_grant_a) begin
         w_rr_next = LAST_A;
         fifo_push = !a_op;
         fifo_pop  = a_op;
         if (!a_op) fifo_wdata = a_wdata;
      end else if (w_grant_b) begin
         w_rr_next = LAST_B;
         fifo_push = !b_op;
         fifo_pop  = b_op;
         if (!b_op) fifo_wdata = b_wdata;
      end
   end

   assign a_ready = w_grant_a | w_to_a;
   assign b_ready = w_grant_b | w_to_b;
   assign a_err   = w_to_a;
   assign b_err   = w_to_b;

   // A pop response already in flight is hidden while reset is held.
   assign a_rvalid = r_rvalid_a & !rst;
   assign b_rvalid = r_rvalid_b & !rst;
   assign a_rdata  = rst ? '0 : r_rdata_a;
   assign b_rdata  = rst ? '0 : r_rdata_b;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr       <= LAST_B;
         r_cnt_a    <= '0;
         r_cnt_b    <= '0;
         r_rvalid_a <= 1'b0;
         r_rvalid_b <= 1'b0;
         r_rdata_a  <= '0;
         r_rdata_b  <= '0;
      end else begin
         r_rr       <= w_rr_next;
         r_cnt_a    <= cnt_next(a_valid, w_elig_a, w_to_a, r_cnt_a);
         r_cnt_b    <= cnt_next(b_valid, w_elig_b, w_to_b, r_cnt_b);
         r_rvalid_a <= w_grant_a & a_op;
         r_rvalid_b <= w_grant_b & b_op;
         if (w_grant_a && a_op) r_rdata_a <= fifo_rdata;
         if (w_grant_b && b_op) r_rdata_b <= fifo_rdata;
      end
   end

endmodule
